midi_poly_voice_allocator: RTL
==============================

Name: midi_poly_voice_allocator

Overview:
Polyphonic successor to the single-voice MIDI note handler. It takes decoded 3-byte MIDI messages and assigns note-on events to one of NUM_VOICES voice slots, using free-voice reuse and oldest-voice stealing. Per voice it drives a DDS tuning word and an ADSR key-on bit. It sits between midi_decoder and the per-voice DDS/ADSR banks, and reuses tuning_code_lookup for note-to-tuning-word conversion.

Parameters:
NUM_VOICES, 4, number of voice slots (1..16)
TW_WIDTH, 32, DDS tuning word width; must equal the tuning_code_lookup output width
MIDI_CHANNEL, 0, channel (0..15) accepted when OMNI=0
OMNI, 1, 1 = accept all channels; 0 = accept only MIDI_CHANNEL

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
midi_byte_ready  in  1  one-cycle strobe; midi_byte0..2 valid
midi_byte0  in  8  status byte
midi_byte1  in  8  data byte 1 (note / controller number)
midi_byte2  in  8  data byte 2 (velocity / controller value)
dds_frequency  out  NUM_VOICES*TW_WIDTH  packed tuning words; voice v at [v*TW_WIDTH +: TW_WIDTH]
key_state  out  NUM_VOICES  per-voice key-on (ADSR gate)
voice_note  out  NUM_VOICES*7  note currently or last held per voice
busy  out  1  high while a message is being processed

Behaviour:
- Single clock domain (clk). Reset is synchronous and active-high (reset).
- Reset: dds_frequency=0, key_state=0, voice_note=0, busy=0, all age counters=0, FSM=IDLE.
- Reset mid-operation aborts the message in flight; no partial voice update is committed.
- FSM IDLE:
  - On midi_byte_ready=1, register the three bytes, set busy=1 and go to LOOKUP.
  - midi_byte_ready is ignored while busy=1; the upstream decoder guarantees at least 3 cycles between strobes.
- FSM LOOKUP:
  - Registered note byte drives tuning_code_lookup (combinational).
  - Classify the message. Channel = byte0[3:0], checked against the OMNI/MIDI_CHANNEL filter. A rejected channel is treated as NOP.
    - NOTE_ON: status 9x with velocity != 0.
    - NOTE_OFF: status 8x, or 9x with velocity 0.
    - ALL_OFF: Bx with byte1=123.
    - Everything else: NOP.
  - Go to APPLY.
- FSM APPLY: commit the action below, then busy=0 and return to IDLE. Outputs change on the clock edge leaving APPLY, i.e. 3 cycles after the strobe cycle.
- NOTE_ON allocation priority:
  - (a) A voice with key_state=1 and the same note: retrigger it (age reset only; key_state stays 1).
  - (b) Otherwise the free voice (key_state=0) with the largest age; ties go to the lowest index.
  - (c) Otherwise steal the active voice with the largest age; ties go to the lowest index.
  - The selected voice gets dds_frequency=tuning_code, voice_note=note, key_state=1, age=0.
  - Every other voice's age increments, saturating at 255 (8-bit counters).
- NOTE_OFF: every voice with key_state=1 and a matching voice_note gets key_state=0. dds_frequency and voice_note are retained so the ADSR release plays at the correct pitch. Ages are unchanged. An unmatched note-off has no effect.
- ALL_OFF: key_state cleared for all voices; everything else unchanged.
- Note byte bit 7 is ignored (only 7 bits are used). Velocity is not stored.

Optional Feature:
SUSTAIN_PEDAL_EN
- Defined:
  - CC64 (Bx, byte1=64) sets sustain=1 when byte2>=64 and sustain=0 otherwise; sustain resets to 0.
  - While sustain=1, NOTE_OFF sets a per-voice held bit instead of clearing key_state.
  - On the 1->0 sustain transition, every held voice gets key_state=0 and held cleared.
  - NOTE_ON retrigger (a) and steal (c) clear the chosen voice's held bit.
  - Held voices count as active for allocation.
  - ALL_OFF clears key_state and held, but not sustain.
- Undefined: CC64 is NOP; no held bits and no sustain register are synthesised.

Test Plan:
- Reset, then 90 3C 64 -> 3 cycles later voice0: key_state=0001, voice_note=60, dds_frequency[31:0]=lookup(60); busy high for exactly 3 cycles.
- Notes 60,62,64,65 on, then 67 on -> voices 0-3 filled in order, then voice0 (oldest) stolen: voice_note0=67, key_state=1111.
- After 4 notes, 80 3E 00 (off 62) then 90 43 40 -> voice1 key_state drops; 67 goes to voice1; voice1 dds retained between off and reallocation.
- 90 3C 00 and B0 7B 00 -> zero-velocity note-on clears the matching voice; ALL_OFF gives key_state=0000 with dds_frequency unchanged; OMNI=0, MIDI_CHANNEL=2: 91 3C 64 gives no change.
- Reset asserted in the LOOKUP cycle of 90 3C 64 -> all outputs 0, FSM IDLE, no voice allocated; midi_byte_ready during busy is ignored.
- SUSTAIN_PEDAL_EN: B0 40 7F, 90 3C 64, 80 3C 00 -> key_state stays 1; B0 40 00 -> key_state0=0.

Source files
------------

// File: rtl/midi_poly_voice_allocator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | midi_poly_voice_allocator                                                  |
// | Polyphonic MIDI note-to-voice allocator: free-voice reuse, oldest-voice    |
// | stealing, per-voice DDS tuning word and ADSR key gate.                     |
// | Optional: `define SUSTAIN_PEDAL_EN enables CC64 sustain with held voices.  |
// | Contains tuning_code_lookup (note -> DDS tuning word at 48 kHz).           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+

module tuning_code_lookup #(
    parameter int TW_WIDTH = 32
) (
    input  logic [6:0]          note,
    output logic [TW_WIDTH-1:0] tuning_code
);
    logic [3:0]  octave;
    logic [3:0]  semitone;
    logic [3:0]  shamt;
    logic [31:0] base;

    // Top-octave words (notes 120..131); lower octaves are right shifts.
    always_comb begin
        octave   = 4'(note / 7'd12);
        semitone = 4'(note % 7'd12);
        shamt    = 4'd10 - octave;
        case (semitone)
            4'd0:    base = 32'd749115488;
            4'd1:    base = 32'd793660256;
            4'd2:    base = 32'd840853760;
            4'd3:    base = 32'd890853536;
            4'd4:    base = 32'd943826432;
            4'd5:    base = 32'd999949280;
            4'd6:    base = 32'd1059409376;
            4'd7:    base = 32'd1122405152;
            4'd8:    base = 32'd1189146848;
            4'd9:    base = 32'd1259857216;
            4'd10:   base = 32'd1334772224;
            default: base = 32'd1414141920;
        endcase
        tuning_code = TW_WIDTH'(base >> shamt);
    end
endmodule

module midi_poly_voice_allocator #(
    parameter int NUM_VOICES   = 4,
    parameter int TW_WIDTH     = 32,
    parameter int MIDI_CHANNEL = 0,
    parameter int OMNI         = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           midi_byte_ready,
    input  logic [7:0]                     midi_byte0,
    input  logic [7:0]                     midi_byte1,
    input  logic [7:0]                     midi_byte2,
    output logic [NUM_VOICES*TW_WIDTH-1:0] dds_frequency,
    output logic [NUM_VOICES-1:0]          key_state,
    output logic [NUM_VOICES*7-1:0]        voice_note,
    output logic                           busy
);
    localparam int VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOOKUP = 2'd1,
        S_APPLY  = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        A_NOP      = 3'd0,
        A_NOTE_ON  = 3'd1,
        A_NOTE_OFF = 3'd2,
        A_ALL_OFF  = 3'd3,
        A_SUS_ON   = 3'd4,
        A_SUS_OFF  = 3'd5
    } act_t;

    state_t                state_q;
    act_t                  act_q;
    act_t                  act_d;
    logic                  busy_q;
    logic [7:0]            byte0_q;
    logic [7:0]            byte1_q;
    logic [7:0]            byte2_q;
    logic [NUM_VOICES-1:0] key_q;
    logic [6:0]            note_q [NUM_VOICES];
    logic [TW_WIDTH-1:0]   tw_q   [NUM_VOICES];
    logic [7:0]            age_q  [NUM_VOICES];
`ifdef SUSTAIN_PEDAL_EN
    logic                  sustain_q;
    logic [NUM_VOICES-1:0] held_q;
`endif

    logic [6:0]          msg_note;
    logic [TW_WIDTH-1:0] lookup_tw;
    logic                chan_ok;

    assign msg_note = byte1_q[6:0];
    assign chan_ok  = (OMNI != 0) || (byte0_q[3:0] == 4'(MIDI_CHANNEL));

    tuning_code_lookup #(.TW_WIDTH(TW_WIDTH)) u_lookup (
        .note        (msg_note),
        .tuning_code (lookup_tw)
    );

    always_comb begin
        act_d = A_NOP;
        if (chan_ok) begin
            case (byte0_q[7:4])
                4'h9: act_d = (byte2_q != 8'd0) ? A_NOTE_ON : A_NOTE_OFF;
                4'h8: act_d = A_NOTE_OFF;
                4'hB: begin
                    if (byte1_q == 8'd123) begin
                        act_d = A_ALL_OFF;
                    end
`ifdef SUSTAIN_PEDAL_EN
                    else if (byte1_q == 8'd64) begin
                        act_d = (byte2_q >= 8'd64) ? A_SUS_ON : A_SUS_OFF;
                    end
`endif
                end
                default: act_d = A_NOP;
            endcase
        end
    end

    // Priority: retrigger same held note, else oldest free, else oldest active.
    logic              hit_found;
    logic              free_found;
    logic              old_found;
    logic [VIDX_W-1:0] hit_idx;
    logic [VIDX_W-1:0] free_idx;
    logic [VIDX_W-1:0] old_idx;
    logic [VIDX_W-1:0] sel_idx;
    logic [7:0]        free_age;
    logic [7:0]        old_age;

    always_comb begin
        hit_found  = 1'b0;
        free_found = 1'b0;
        old_found  = 1'b0;
        hit_idx    = '0;
        free_idx   = '0;
        old_idx    = '0;
        free_age   = '0;
        old_age    = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (!hit_found && key_q[v] && (note_q[v] == msg_note)) begin
                hit_found = 1'b1;
                hit_idx   = VIDX_W'(v);
            end
            if (!key_q[v] && (!free_found || (age_q[v] > free_age))) begin
                free_found = 1'b1;
                free_idx   = VIDX_W'(v);
                free_age   = age_q[v];
            end
            if (key_q[v] && (!old_found || (age_q[v] > old_age))) begin
                old_found = 1'b1;
                old_idx   = VIDX_W'(v);
                old_age   = age_q[v];
            end
        end
        sel_idx = hit_found ? hit_idx : (free_found ? free_idx : old_idx);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            act_q   <= A_NOP;
            busy_q  <= 1'b0;
            byte0_q <= '0;
            byte1_q <= '0;
            byte2_q <= '0;
            key_q   <= '0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                note_q[v] <= '0;
                tw_q[v]   <= '0;
                age_q[v]  <= '0;
            end
`ifdef SUSTAIN_PEDAL_EN
            sustain_q <= 1'b0;
            held_q    <= '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (midi_byte_ready) begin
                        byte0_q <= midi_byte0;
                        byte1_q <= midi_byte1;
                        byte2_q <= midi_byte2;
                        busy_q  <= 1'b1;
                        state_q <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    act_q   <= act_d;
                    state_q <= S_APPLY;
                end
                S_APPLY: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                    case (act_q)
                        A_NOTE_ON: begin
                            for (int v = 0; v < NUM_VOICES; v++) begin
                                if (sel_idx == VIDX_W'(v)) begin
                                    tw_q[v]   <= lookup_tw;
                                    note_q[v] <= msg_note;
                                    key_q[v]  <= 1'b1;
                                    age_q[v]  <= '0;
`ifdef SUSTAIN_PEDAL_EN
                                    held_q[v] <= 1'b0;
`endif
                                end else if (age_q[v] != 8'hFF) begin
                                    age_q[v] <= age_q[v] + 8'd1;
                                end
                            end
                        end
                        A_NOTE_OFF: begin
                            for (int v = 0; v < NUM_VOICES; v++) begin
                                if (key_q[v] && (note_q[v] == msg_note)) begin
`ifdef SUSTAIN_PEDAL_EN
                                    if (sustain_q) begin
                                        held_q[v] <= 1'b1;
                                    end else begin
                                        key_q[v] <= 1'b0;
                                    end
`else
                                    key_q[v] <= 1'b0;
`endif
                                end
                            end
                        end
                        A_ALL_OFF: begin
                            key_q <= '0;
`ifdef SUSTAIN_PEDAL_EN
                            held_q <= '0;
`endif
                        end
`ifdef SUSTAIN_PEDAL_EN
                        A_SUS_ON: sustain_q <= 1'b1;
                        A_SUS_OFF: begin
                            sustain_q <= 1'b0;
                            key_q     <= key_q & ~held_q;
                            held_q    <= '0;
                        end
`endif
                        default: ;
                    endcase
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    generate
        for (genvar g = 0; g < NUM_VOICES; g++) begin : g_pack
            assign dds_frequency[g*TW_WIDTH +: TW_WIDTH] = tw_q[g];
            assign voice_note[g*7 +: 7]                  = note_q[g];
        end
    endgenerate

    assign key_state = key_q;
    // Busy already covers the strobe cycle so upstream sees it for the full window.
    assign busy = busy_q | ((state_q == S_IDLE) & midi_byte_ready);

endmodule
`default_nettype wire
